// File: rtl/des_sbox_pkg.sv
// Shared definitions for the iterative DES S-box unit: FIPS 46-3 S-box
// tables, table lookup helper, FSM state type and iteration-count helper.
package des_sbox_pkg;

    // S1..S8, each stored row-major: entry [row*16 + col].
    localparam logic [3:0] SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sbox_state_t;

    // Raw chunk bit 5 is DES b1, bit 0 is b6: row = {b1,b6}, col = b2..b5.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] idx);
        return SBOX[box][{idx[5], idx[0], idx[4:1]}];
    endfunction

    function automatic int sbox_iter(input int lanes);
        return 8 / lanes;
    endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// One combinational S-box lane: box select plus raw 6-bit chunk to 4-bit result.
module des_sbox_lane
    import des_sbox_pkg::*;
(
    input  logic [2:0] i_box,
    input  logic [5:0] i_chunk,
    output logic [3:0] o_nib
);

    // Table lookup for the selected box.
    always_comb begin
        o_nib = sbox_lookup(i_box, i_chunk);
    end

endmodule

// File: rtl/des_sbox_seq.sv
// Iterative DES S-box unit: 48-bit word in, S1..S8 concatenation out,
// LANES boxes per clock. Optional macro DES_SBOX_CNT_EN adds the blk_cnt
// output counting completed output handshakes.
module des_sbox_seq
    import des_sbox_pkg::*;
#(
    parameter int LANES = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef DES_SBOX_CNT_EN
    ,
    output logic [15:0]      blk_cnt
`endif
);

    localparam int ITER  = sbox_iter(LANES);
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
    end

    sbox_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [47:0]      r_word;
    logic [31:0]      r_result;
    logic [TAG_W-1:0] r_tag;

    logic [2:0]  w_box   [LANES];
    logic [5:0]  w_chunk [LANES];
    logic [3:0]  w_nib   [LANES];
    logic [31:0] w_result_nxt;

    // Select this cycle's boxes and their chunks from the latched word.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            w_box[l]   = 3'(r_cnt * LANES + l);
            w_chunk[l] = 6'(r_word >> (6 * (3'd7 - w_box[l])));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        des_sbox_lane u_lane (
            .i_box   (w_box[g]),
            .i_chunk (w_chunk[g]),
            .o_nib   (w_nib[g])
        );
    end

    // Merge this cycle's lane nibbles into the accumulated result.
    always_comb begin
        w_result_nxt = r_result;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_result_nxt[4 * (3'd7 - w_box[l]) +: 4] = w_nib[l];
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_word   <= '0;
            r_result <= '0;
            r_tag    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_word   <= in_data;
                        r_tag    <= in_tag;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result <= w_result_nxt;
                    if (r_cnt == CNT_W'(ITER - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DES_SBOX_CNT_EN
    logic [15:0] r_blk_cnt;

    // Count completed output handshakes, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (r_state == ST_DONE && out_ready) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_result;
    assign out_tag   = r_tag;

endmodule
